truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning DUT input vector width, legal range 1..8.
REQ-002 SHALL have parameter N_OUT, default 4, meaning DUT output channel count, legal range 1..8.
REQ-003 SHALL have parameter HOLD, default 2, meaning clocks each pattern is held, legal range 1..255.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a sweep.
REQ-007 SHALL have port abort  input  1  request to terminate a sweep early.
REQ-008 SHALL have port gray_mode  input  1  0 gives binary order, 1 gives Gray order; sampled at sweep start.
REQ-009 SHALL have port dut_out  input  N_OUT  DUT responses, one bit per channel.
REQ-010 SHALL have port pattern  output  N_IN  stimulus driven to the DUT.
REQ-011 SHALL have port busy  output  1  high while a sweep is running.
REQ-012 SHALL have port sample_valid  output  1  one-cycle pulse when dut_out is captured.
REQ-013 SHALL have port sample_data  output  N_OUT  last captured dut_out.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a sweep completes normally.
REQ-015 SHALL have port signature  output  16  response signature, held until the next sweep starts.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL move IDLE->RUN on start=1; at that point index, hold counter and mode latch load, and signature loads its seed.
REQ-018 SHALL ignore start while in RUN or DONE.
REQ-019 SHALL drive pattern = index in binary mode and index^(index>>1) in Gray mode, starting the cycle after start.
REQ-020 SHALL hold each pattern exactly HOLD cycles, counted by hold_cnt running 0..HOLD-1.
REQ-021 SHALL capture dut_out into sample_data when hold_cnt==HOLD-1, pulse sample_valid in the following cycle, and update the signature on the same capture edge.
REQ-022 SHALL, on a capture with index<2^N_IN-1, increment index and clear hold_cnt.
REQ-023 SHALL, on a capture with index==2^N_IN-1, go RUN->DONE; DONE pulses done for one cycle and then returns to IDLE.
REQ-024 SHALL, with abort=1 in RUN, go to IDLE on the next edge with no done pulse, leave signature frozen at its partial value, and return pattern to 0.
REQ-025 SHALL let abort win over capture when both occur in the same cycle.
REQ-026 SHALL ignore abort outside RUN.
REQ-027 SHALL keep busy=1 exactly while in RUN.
REQ-028 SHALL hold pattern at 0 while in IDLE.
REQ-029 SHALL perform 2^N_IN captures per full sweep, for a total of HOLD*2^N_IN RUN cycles.

Reset
REQ-030 SHALL, on rst=1, asynchronously force state=IDLE, pattern=0, busy=0, done=0, sample_valid=0, sample_data=0 and signature=16'hFFFF.
REQ-031 SHALL abandon an in-progress sweep on reset with no done pulse, and SHALL accept start on the first edge after reset deasserts.

Configuration
REQ-032 SHALL, with TTSEQ_MISR_EN defined, compute signature as a 16-bit MISR on each capture:
- seed 16'hFFFF
- sig <= {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended dut_out
REQ-033 SHALL, with TTSEQ_MISR_EN undefined, tie signature to 0 with no MISR logic synthesised; all other behaviour is unchanged.

Structure
REQ-034 SHALL place the following in package ttseq_pkg:
- the state enum (IDLE, RUN, DONE)
- MISR polynomial 16'h1021
- MISR seed 16'hFFFF
- width 16
REQ-035 SHALL implement the MISR as sub-module ttseq_misr (ports clk, rst, load, en, din, sig), instantiated only under TTSEQ_MISR_EN.

Verification
REQ-036 SHALL cover a binary sweep:
- setup: N_IN=3, HOLD=1, gray_mode=0, start pulse
- response: pattern 0,1,...,7 on consecutive cycles; 8 sample_valid pulses; done once; busy high for 8 cycles
REQ-037 SHALL cover a Gray sweep:
- setup: N_IN=3, gray_mode=1
- response: pattern 0,1,3,2,6,7,5,4
REQ-038 SHALL cover hold timing:
- setup: N_IN=2, HOLD=3
- response: each pattern stable 3 cycles; capture on the third cycle; 12 busy cycles
REQ-039 SHALL cover a known signature:
- setup: TTSEQ_MISR_EN defined, N_IN=1, N_OUT=1, dut_out=0
- response: signature EFDF after the first capture and CF9F at done
REQ-040 SHALL cover abort:
- setup: abort at index 2 (also asserted together with a capture)
- response: IDLE next cycle, no done, pattern=0, signature frozen
REQ-041 SHALL cover reset and start collisions:
- setup: rst mid-sweep, then start during RUN
- response: outputs reach reset values immediately; a start during RUN does not restart the index

Source files
------------

// File: rtl/ttseq_pkg.sv
// Shared types and constants for the truth-table sequencer.
// Holds the FSM state enum, MISR polynomial/seed/width and one MISR step function.
package ttseq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int unsigned SIG_W     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  function automatic logic [15:0] misr_step(
    input logic [15:0] s,
    input logic [15:0] d
  );
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/ttseq_misr.sv
// 16-bit MISR that folds one response word into the signature per enable.
// Ports: clk, rst (async high), load (reseed), en (fold din), din, sig.
module ttseq_misr
  import ttseq_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DW-1:0]    din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = MISR_SEED;
    end else if (en) begin
      sig_d = misr_step(sig_q, SIG_W'(din));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every N_IN-bit input pattern (binary or Gray order), holding each
// for HOLD clocks and capturing the DUT response on the last hold cycle.
// Ports: clk, rst (async high), start, abort, gray_mode, dut_out in;
//        pattern, busy, sample_valid, sample_data, done, signature out.
// Define TTSEQ_MISR_EN to build the response MISR; otherwise signature is 0.
module truth_table_sequencer
  import ttseq_pkg::*;
#(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             gray_mode,
  input  logic [N_OUT-1:0] dut_out,
  output logic [N_IN-1:0]  pattern,
  output logic             busy,
  output logic             sample_valid,
  output logic [N_OUT-1:0] sample_data,
  output logic             done,
  output logic [15:0]      signature
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] IDX_LAST  = '1;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             gray_q, gray_d;
  logic             sv_q, sv_d;
  logic [N_OUT-1:0] sd_q, sd_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    gray_d  = gray_q;
    sv_d    = 1'b0;
    sd_d    = sd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          hold_d  = '0;
          gray_d  = gray_mode;
        end
      end
      RUN: begin
        // abort pre-empts a capture landing on the same edge
        if (abort) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          sv_d = 1'b1;
          sd_d = dut_out;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      gray_q  <= 1'b0;
      sv_q    <= 1'b0;
      sd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gray_q  <= gray_d;
      sv_q    <= sv_d;
      sd_q    <= sd_d;
    end
  end

  // pattern is only live in RUN, so reset/abort/idle force it to 0
  assign pattern = (state_q != RUN) ? '0 :
                   gray_q ? (idx_q ^ (idx_q >> 1)) : idx_q;

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign sample_valid = sv_q;
  assign sample_data  = sd_q;

`ifdef TTSEQ_MISR_EN
  logic launch;
  logic capture;

  assign launch  = (state_q == IDLE) && start;
  assign capture = (state_q == RUN) && !abort &&
                   (hold_q == HOLD_LAST);

  ttseq_misr #(
    .DW(N_OUT)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .load(launch),
    .en  (capture),
    .din (dut_out),
    .sig (signature)
  );
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench for truth_table_sequencer: three instances cover the
// 3-bit sweeps/abort/reset, 2-bit HOLD=3 timing and 1-bit signature cases.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int errors = 0;
  int checks = 0;

`ifdef TTSEQ_MISR_EN
  localparam bit MISR = 1'b1;
`else
  localparam bit MISR = 1'b0;
`endif
  localparam logic [15:0] SIG_RST = MISR ? 16'hFFFF : 16'h0000;

  // instance A: N_IN=3 N_OUT=4 HOLD=1
  logic a_start, a_abort, a_gray, a_busy, a_sv, a_done;
  logic [3:0] a_dout, a_sd;
  logic [2:0] a_pat;
  logic [15:0] a_sig;
  // instance B: N_IN=2 N_OUT=2 HOLD=3
  logic b_start, b_abort, b_busy, b_sv, b_done;
  logic [1:0] b_dout, b_sd, b_pat;
  logic [15:0] b_sig;
  // instance C: N_IN=1 N_OUT=1 HOLD=1
  logic c_start, c_abort, c_busy, c_sv, c_done;
  logic [0:0] c_dout, c_sd, c_pat;
  logic [15:0] c_sig;

  logic [3:0] aq[$];
  logic [1:0] bq[$];
  logic [0:0] cq[$];

  logic [2:0] gray3 [8];
  logic [2:0] bin3 [8];

  function automatic logic [3:0] fa(input logic [2:0] p);
    return {^p, p};
  endfunction

  function automatic logic [1:0] fb(input logic [1:0] p);
    return {p[0], ~p[1]};
  endfunction

  function automatic logic [15:0] mstep(
    input logic [15:0] s,
    input logic [15:0] d
  );
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  assign a_dout = fa(a_pat);
  assign b_dout = fb(b_pat);
  assign c_dout = 1'b0;

  truth_table_sequencer #(
    .N_IN(3), .N_OUT(4), .HOLD(1)
  ) u_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .gray_mode(a_gray), .dut_out(a_dout), .pattern(a_pat),
    .busy(a_busy), .sample_valid(a_sv), .sample_data(a_sd),
    .done(a_done), .signature(a_sig)
  );

  truth_table_sequencer #(
    .N_IN(2), .N_OUT(2), .HOLD(3)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .gray_mode(1'b0), .dut_out(b_dout), .pattern(b_pat),
    .busy(b_busy), .sample_valid(b_sv), .sample_data(b_sd),
    .done(b_done), .signature(b_sig)
  );

  truth_table_sequencer #(
    .N_IN(1), .N_OUT(1), .HOLD(1)
  ) u_c (
    .clk(clk), .rst(rst), .start(c_start), .abort(c_abort),
    .gray_mode(1'b0), .dut_out(c_dout), .pattern(c_pat),
    .busy(c_busy), .sample_valid(c_sv), .sample_data(c_sd),
    .done(c_done), .signature(c_sig)
  );

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitors: pop expected capture data on every sample_valid pulse
  always @(negedge clk) begin
    if (!rst && a_sv) begin
      if (aq.size() == 0) chk("a_extra_sample", 32'(a_sd), 32'hDEAD);
      else chk("a_sample", 32'(a_sd), 32'(aq.pop_front()));
    end
    if (!rst && b_sv) begin
      if (bq.size() == 0) chk("b_extra_sample", 32'(b_sd), 32'hDEAD);
      else chk("b_sample", 32'(b_sd), 32'(bq.pop_front()));
    end
    if (!rst && c_sv) begin
      if (cq.size() == 0) chk("c_extra_sample", 32'(c_sd), 32'hDEAD);
      else chk("c_sample", 32'(c_sd), 32'(cq.pop_front()));
    end
  end

  // ab_at / rs_at: cycle index at which to raise abort / a stray start
  task automatic sweep_a(input bit g, input int ab_at, input int rs_at);
    int nb;
    int nd;
    int ncap;
    logic [15:0] sig;
    logic [2:0] p;
    nb = 0;
    nd = 0;
    sig = 16'hFFFF;
    ncap = (ab_at >= 0) ? ab_at : 8;
    for (int k = 0; k < ncap; k++) begin
      p = g ? gray3[k] : bin3[k];
      aq.push_back(fa(p));
      sig = mstep(sig, 16'(fa(p)));
    end
    a_gray = g;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    a_gray = ~g;
    for (int c = 0; c < 12; c++) begin
      if (a_busy) begin
        if (nb < 8)
          chk("a_pattern", 32'(a_pat), 32'(g ? gray3[nb] : bin3[nb]));
        nb++;
      end else if (!a_done) begin
        chk("a_idle_pattern", 32'(a_pat), 32'd0);
      end
      if (a_done) nd++;
      if (c == ab_at) a_abort = 1'b1;
      if (c == rs_at) a_start = 1'b1;
      @(posedge clk);
      #1;
      a_abort = 1'b0;
      a_start = 1'b0;
    end
    chk("a_busy_cycles", 32'(nb), 32'((ab_at >= 0) ? ab_at + 1 : 8));
    chk("a_done_pulses", 32'(nd), 32'((ab_at >= 0) ? 0 : 1));
    chk("a_signature", 32'(a_sig), 32'(MISR ? sig : 16'h0000));
    chk("a_queue_drained", 32'(aq.size()), 32'd0);
  endtask

  task automatic sweep_b;
    int nb;
    int nd;
    logic [15:0] sig;
    nb = 0;
    nd = 0;
    sig = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      bq.push_back(fb(2'(k)));
      sig = mstep(sig, 16'(fb(2'(k))));
    end
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int c = 0; c < 17; c++) begin
      if (b_busy) begin
        chk("b_pattern", 32'(b_pat), 32'(nb / 3));
        nb++;
      end
      chk("b_sv_timing", 32'(b_sv),
          32'((c >= 3 && c <= 12 && c % 3 == 0) ? 1 : 0));
      if (b_done) nd++;
      @(posedge clk);
      #1;
    end
    chk("b_busy_cycles", 32'(nb), 32'd12);
    chk("b_done_pulses", 32'(nd), 32'd1);
    chk("b_signature", 32'(b_sig), 32'(MISR ? sig : 16'h0000));
    chk("b_queue_drained", 32'(bq.size()), 32'd0);
  endtask

  task automatic sweep_c;
    cq.push_back(1'b0);
    cq.push_back(1'b0);
    c_start = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    chk("c_busy_first", 32'(c_busy), 32'd1);
    @(posedge clk);
    #1;
    chk("c_sig_first", 32'(c_sig), 32'(MISR ? 16'hEFDF : 16'h0000));
    @(posedge clk);
    #1;
    chk("c_done", 32'(c_done), 32'd1);
    chk("c_sig_done", 32'(c_sig), 32'(MISR ? 16'hCF9F : 16'h0000));
    @(posedge clk);
    #1;
    chk("c_done_one_cycle", 32'(c_done), 32'd0);
    chk("c_idle", 32'(c_busy), 32'd0);
    chk("c_queue_drained", 32'(cq.size()), 32'd0);
  endtask

  task automatic chk_a_reset(input string tag);
    chk({tag, "_busy"}, 32'(a_busy), 32'd0);
    chk({tag, "_pattern"}, 32'(a_pat), 32'd0);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
    chk({tag, "_sv"}, 32'(a_sv), 32'd0);
    chk({tag, "_sd"}, 32'(a_sd), 32'd0);
    chk({tag, "_sig"}, 32'(a_sig), 32'(SIG_RST));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bin3  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    gray3 = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    rst = 1'b1;
    {a_start, a_abort, a_gray} = '0;
    {b_start, b_abort} = '0;
    {c_start, c_abort} = '0;
    #12;
    chk_a_reset("rst0_a");
    chk("rst0_b_busy", 32'(b_busy), 32'd0);
    chk("rst0_c_sig", 32'(c_sig), 32'(SIG_RST));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    sweep_a(1'b0, -1, -1);
    sweep_a(1'b1, -1, -1);
    sweep_a(1'b0, 2, -1);

    // abort while idle must not block a following start
    a_abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(a_busy), 32'd0);
    a_abort = 1'b0;
    sweep_a(1'b1, -1, -1);

    sweep_b();
    sweep_c();

    // reset mid-sweep: only the first capture escapes before rst
    aq.push_back(fa(3'd0));
    a_start = 1'b1;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_a_reset("rst_mid_a");
    chk("rst_mid_queue", 32'(aq.size()), 32'd0);
    aq.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    // start on first edge after release; stray start at index 3 ignored
    sweep_a(1'b0, -1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
